// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing controller for the M-extension multiply/divide unit.
// Optional single-entry result cache: define MDU_RESULT_CACHE_EN.
module mdu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic        mdu_start_o,
    output logic [2:0]  mdu_op_o,
    output logic [31:0] mdu_a_o,
    output logic [31:0] mdu_b_o,
    input  logic        mdu_done_i,
    input  logic [31:0] mdu_result_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic        err_q, err_d;

    logic        accept;
    logic        wd_hit;
    logic        b_zero;
    logic        ovf;
    logic        fast;
    logic [31:0] fast_res;
    logic        c_hit;
    logic [31:0] c_res;
    logic        c_wr;
    logic        c_inv;

    assign accept = req_valid_i && req_ready_o && !flush_i;
    assign wd_hit = (TIMEOUT_CYCLES != 0) &&
                    ((cnt_q + 32'd1) >= 32'(TIMEOUT_CYCLES));
    assign b_zero = (req_b_i == 32'd0);
    assign ovf    = (req_a_i == 32'h8000_0000) &&
                    (req_b_i == 32'hFFFF_FFFF);

    always_comb begin
        fast     = 1'b0;
        fast_res = 32'd0;
        unique case (req_op_i)
            OP_DIV: begin
                fast     = b_zero || ovf;
                fast_res = b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            end
            OP_DIVU: begin
                fast     = b_zero;
                fast_res = 32'hFFFF_FFFF;
            end
            OP_REM: begin
                fast     = b_zero || ovf;
                fast_res = b_zero ? req_a_i : 32'd0;
            end
            OP_REMU: begin
                fast     = b_zero;
                fast_res = req_a_i;
            end
            default: begin
                fast     = 1'b0;
                fast_res = 32'd0;
            end
        endcase
    end

`ifdef MDU_RESULT_CACHE_EN
    logic        c_vld_q;
    logic [2:0]  c_op_q;
    logic [31:0] c_a_q;
    logic [31:0] c_b_q;
    logic [31:0] c_res_q;

    assign c_hit = c_vld_q && (c_op_q == req_op_i) &&
                   (c_a_q == req_a_i) && (c_b_q == req_b_i);
    assign c_res = c_res_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_vld_q <= 1'b0;
            c_op_q  <= 3'd0;
            c_a_q   <= 32'd0;
            c_b_q   <= 32'd0;
            c_res_q <= 32'd0;
        end else if (c_inv) begin
            c_vld_q <= 1'b0;
        end else if (c_wr) begin
            c_vld_q <= 1'b1;
            c_op_q  <= op_q;
            c_a_q   <= a_q;
            c_b_q   <= b_q;
            c_res_q <= mdu_result_i;
        end
    end
`else
    assign c_hit = 1'b0;
    assign c_res = 32'd0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        c_wr    = 1'b0;
        c_inv   = flush_i;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = req_op_i;
                    a_d   = req_a_i;
                    b_d   = req_b_i;
                    cnt_d = 32'd0;
                    err_d = 1'b0;
                    if (fast) begin
                        res_d   = fast_res;
                        state_d = RESP;
                    end else if (c_hit) begin
                        res_d   = c_res;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 32'd1;
                if (mdu_done_i && flush_i) begin
                    cnt_d   = 32'd0;
                    state_d = IDLE;
                end else if (mdu_done_i) begin
                    res_d   = mdu_result_i;
                    err_d   = 1'b0;
                    cnt_d   = 32'd0;
                    c_wr    = 1'b1;
                    state_d = RESP;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end else if (wd_hit) begin
                    res_d   = 32'd0;
                    err_d   = 1'b1;
                    cnt_d   = 32'd0;
                    c_inv   = 1'b1;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 32'd1;
                if (mdu_done_i) begin
                    cnt_d   = 32'd0;
                    state_d = IDLE;
                end else if (wd_hit) begin
                    cnt_d   = 32'd0;
                    c_inv   = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (flush_i || resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Start is level-held for the whole BUSY/DRAIN residency.
    assign req_ready_o  = (state_q == IDLE) && !rst_i;
    assign mdu_start_o  = (state_q == BUSY) || (state_q == DRAIN);
    assign mdu_op_o     = op_q;
    assign mdu_a_o      = a_q;
    assign mdu_b_o      = b_q;
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = res_q;
    assign resp_err_o   = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed testbench for mdu_issue_ctrl (watchdog set to 8 cycles).
// Cache expectations follow MDU_RESULT_CACHE_EN when it is defined.
module tb_mdu_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        flush_i;
    logic        mdu_start_o;
    logic [2:0]  mdu_op_o;
    logic [31:0] mdu_a_o;
    logic [31:0] mdu_b_o;
    logic        mdu_done_i;
    logic [31:0] mdu_result_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        busy_o;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .flush_i      (flush_i),
        .mdu_start_o  (mdu_start_o),
        .mdu_op_o     (mdu_op_o),
        .mdu_a_o      (mdu_a_o),
        .mdu_b_o      (mdu_b_o),
        .mdu_done_i   (mdu_done_i),
        .mdu_result_i (mdu_result_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] ures;
        int          rdly;
        logic [31:0] exp_d;
        logic        exp_err;
        int          exp_starts;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issues one request; a unit model raises done on the lat-th start cycle
    // (lat = 0 means the unit never answers).
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ures,
                          input int rdly, input logic [31:0] exp_d,
                          input logic exp_err, input int exp_starts,
                          input int exp_lat);
        int starts;
        int cyc;
        bit got;
        starts = 0;
        cyc = 1;
        got = 0;
        @(negedge clk_i);
        chk({tag, "_ready_idle"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_op_i = op;
        req_a_i = a;
        req_b_i = b;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        while (!got && cyc < 200) begin
            mdu_done_i = 1'b0;
            mdu_result_i = 32'd0;
            if (mdu_start_o) begin
                starts++;
                if (lat > 0 && starts == lat) begin
                    mdu_done_i = 1'b1;
                    mdu_result_i = ures;
                end
            end
            if (resp_valid_o) begin
                got = 1;
            end else begin
                @(negedge clk_i);
                cyc++;
            end
        end
        mdu_done_i = 1'b0;
        chk({tag, "_resp_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_starts"}, 32'(starts), 32'(exp_starts));
        chk({tag, "_data"}, resp_data_o, exp_d);
        chk({tag, "_err"}, 32'(resp_err_o), 32'(exp_err));
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk_i);
            chk({tag, "_bp_valid"}, 32'(resp_valid_o), 32'd1);
            chk({tag, "_bp_data"}, resp_data_o, exp_d);
            chk({tag, "_bp_ready"}, 32'(req_ready_o), 32'd0);
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        chk({tag, "_post_valid"}, 32'(resp_valid_o), 32'd0);
        chk({tag, "_post_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        int resp_seen;
        int drain_starts;

        vecs[0] = '{3'b000, 32'd7, 32'd6, 3, 32'd42, 0,
                    32'd42, 1'b0, 3, 4};
        vecs[1] = '{3'b101, 32'd100, 32'd0, 3, 32'd0, 0,
                    32'hFFFF_FFFF, 1'b0, 0, 1};
        vecs[2] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 3, 32'h1234, 0,
                    32'd0, 1'b0, 0, 1};
        vecs[3] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 3, 32'h1234, 0,
                    32'h8000_0000, 1'b0, 0, 1};
        vecs[4] = '{3'b111, 32'd5, 32'd0, 3, 32'h1234, 0,
                    32'd5, 1'b0, 0, 1};
        vecs[5] = '{3'b110, 32'h8000_0000, 32'd0, 3, 32'h1234, 0,
                    32'h8000_0000, 1'b0, 0, 1};
        vecs[6] = '{3'b100, 32'd100, 32'd7, 2, 32'd14, 5,
                    32'd14, 1'b0, 2, 3};
        vecs[7] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 4, 32'd0, 0,
                    32'd0, 1'b0, 4, 5};
        vecs[8] = '{3'b001, 32'd3, 32'd5, 0, 32'd0, 0,
                    32'd0, 1'b1, 8, 9};
        vecs[9] = '{3'b000, 32'd7, 32'd6, 1, 32'd42, 0,
                    32'd42, 1'b0, 1, 2};

        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_op_i = 3'd0;
        req_a_i = 32'd0;
        req_b_i = 32'd0;
        flush_i = 1'b0;
        mdu_done_i = 1'b0;
        mdu_result_i = 32'd0;
        resp_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_start", 32'(mdu_start_o), 32'd0);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_data", resp_data_o, 32'd0);
        chk("rst_a", mdu_a_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].lat, vecs[i].ures, vecs[i].rdly, vecs[i].exp_d,
                   vecs[i].exp_err, vecs[i].exp_starts, vecs[i].exp_lat);
        end

        // Flush in BUSY: DRAIN holds start until done, no response.
        resp_seen = 0;
        drain_starts = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_a_i = 32'd9;
        req_b_i = 32'd9;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("fl_busy_start", 32'(mdu_start_o), 32'd1);
        chk("fl_op_latched", 32'(mdu_a_o), 32'd9);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (mdu_start_o) drain_starts++;
            if (resp_valid_o) resp_seen++;
            mdu_done_i = (i == 4);
            mdu_result_i = 32'd81;
            if (i < 4) @(negedge clk_i);
        end
        @(negedge clk_i);
        mdu_done_i = 1'b0;
        chk("fl_drain_starts", 32'(drain_starts), 32'd4);
        chk("fl_no_resp", 32'(resp_seen + int'(resp_valid_o)), 32'd0);
        chk("fl_ready_back", 32'(req_ready_o), 32'd1);
        chk("fl_start_low", 32'(mdu_start_o), 32'd0);

        // Flush together with done in BUSY discards the result.
        req_valid_i = 1'b1;
        req_op_i = 3'b000;
        req_a_i = 32'd2;
        req_b_i = 32'd2;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i = 1'b1;
        mdu_done_i = 1'b1;
        mdu_result_i = 32'd4;
        @(negedge clk_i);
        flush_i = 1'b0;
        mdu_done_i = 1'b0;
        chk("fd_idle", 32'(busy_o), 32'd0);
        chk("fd_no_resp", 32'(resp_valid_o), 32'd0);

        // Flush in the accept cycle blocks the request.
        req_valid_i = 1'b1;
        req_op_i = 3'b101;
        req_a_i = 32'd1;
        req_b_i = 32'd0;
        flush_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        chk("fa_not_accepted", 32'(busy_o), 32'd0);

        // Done in IDLE is ignored.
        mdu_done_i = 1'b1;
        @(negedge clk_i);
        mdu_done_i = 1'b0;
        chk("done_idle", 32'(busy_o), 32'd0);

        // Flush in RESP drops the response.
        req_valid_i = 1'b1;
        req_op_i = 3'b101;
        req_a_i = 32'd1;
        req_b_i = 32'd0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("fr_valid", 32'(resp_valid_o), 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("fr_dropped", 32'(resp_valid_o), 32'd0);
        chk("fr_ready", 32'(req_ready_o), 32'd1);

        // Repeated MULHU, then a flush, then the same request again.
        run_op("c1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,
               32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 1'b0, 3, 4);
`ifdef MDU_RESULT_CACHE_EN
        run_op("c2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,
               32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 1'b0, 0, 1);
`else
        run_op("c2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,
               32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 1'b0, 3, 4);
`endif
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        run_op("c3", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3,
               32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 1'b0, 3, 4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequencing controller between the execute stage and the multiply/divide unit.
- Accepts one M-extension operation at a time on a valid/ready request channel and latches the operands and funct3.
- Drives the unit's level-held start until done, captures the result, and returns it on a valid/ready response channel.
- Resolves divide-by-zero and signed-overflow cases itself in one cycle, without starting the unit; also provides flush and a watchdog.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in BUSY before forced error completion; 0 disables the watchdog.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  controller can accept a request
req_op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_a_i  input  32  rs1 operand
req_b_i  input  32  rs2 operand
flush_i  input  1  pipeline flush; discard the in-flight operation
mdu_start_o  output  1  start to the unit, held high until mdu_done_i
mdu_op_o  output  3  latched funct3
mdu_a_o  output  32  latched operand A
mdu_b_o  output  32  latched operand B
mdu_done_i  input  1  unit finished; mdu_result_i is valid
mdu_result_i  input  32  unit result, already selected by op
resp_valid_o  output  1  response valid
resp_ready_i  input  1  consumer accepts the response
resp_data_o  output  32  result
resp_err_o  output  1  watchdog timeout (resp_data_o = 0)
busy_o  output  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-high, clock is clk_i. All outputs reset to 0 (req_ready_o = 1 once reset deasserts); state = IDLE; operand, op and result registers = 0; watchdog counter = 0.
- States are IDLE, BUSY, DRAIN, RESP.
- IDLE:
  - req_ready_o = 1.
  - A request is accepted on the clock edge where req_valid_i && req_ready_o; op, a and b are latched.
  - If flush_i is high in the same cycle, the request is not accepted.
- Fast path on accept (next state RESP, result registered, mdu_start_o never asserted):
  - DIV/DIVU with b == 0: result = 0xFFFFFFFF.
  - REM/REMU with b == 0: result = a.
  - DIV with a == 0x80000000 and b == 0xFFFFFFFF: result = 0x80000000.
  - REM with the same operands: result = 0.
- Otherwise, on accept: next state BUSY.
- BUSY:
  - mdu_start_o = 1 with latched op/a/b stable; watchdog counter increments each cycle.
  - On mdu_done_i: capture mdu_result_i, clear the counter, go to RESP.
  - flush_i (without done): go to DRAIN.
  - flush_i together with mdu_done_i: discard the result, go to IDLE.
- DRAIN:
  - mdu_start_o stays 1 so the unit completes cleanly.
  - On mdu_done_i, discard the result and go to IDLE.
  - No response is issued.
- Watchdog:
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES while in BUSY or DRAIN, drop mdu_start_o.
  - From BUSY: go to RESP with resp_err_o = 1 and data = 0.
  - From DRAIN: go to IDLE.
- RESP:
  - resp_valid_o = 1; resp_data_o and resp_err_o stay stable until the handshake.
  - On resp_valid_o && resp_ready_i, go to IDLE; req_ready_o rises the following cycle, so back-to-back throughput is one op per (latency + 2) cycles.
  - flush_i in RESP: drop the response and go to IDLE.
- Minimum latency from accept to resp_valid_o: 1 cycle (fast path); 1 + unit latency (normal path).
- A mdu_done_i in IDLE or RESP is ignored.

Optional Feature:
- Macro name: MDU_RESULT_CACHE_EN.
- Defined:
  - Keeps one entry {valid, op, a, b, result}, written on every normal-path completion without error.
  - A request whose op, a and b all match a valid entry takes the fast path (RESP next cycle, start not asserted).
  - The entry is invalidated on reset, on any flush_i, and on watchdog timeout.
- Undefined: no cache storage; every non-special request goes through BUSY.

Test Plan:
- MUL a=7, b=6, unit done 3 cycles after start → mdu_start_o high exactly 3 cycles; resp_data_o = 42; resp_err_o = 0; one response.
- DIVU a=100, b=0 → resp_valid_o the cycle after accept, data 0xFFFFFFFF, start never high. REM a=0x80000000, b=0xFFFFFFFF → data 0.
- Backpressure: DIV 100/7 with resp_ready_i held low 5 cycles → data 14 held stable and req_ready_o low throughout; accepted on the first ready cycle.
- Flush in BUSY with the unit done 4 cycles later → DRAIN keeps start high until done; no resp_valid_o; req_ready_o returns the cycle after done.
- TIMEOUT_CYCLES=8 and mdu_done_i never asserted → after 8 BUSY cycles start drops; response with err=1, data=0.
- With MDU_RESULT_CACHE_EN: MULHU 0xFFFFFFFF × 0xFFFFFFFF twice → first goes through BUSY (0xFFFFFFFE); second responds next cycle with no start. After a flush, the same request uses BUSY again.
